// File: rtl/oa_addr_gen_if.sv
// IA input / OA output stream bundle for oa_addr_gen; packed per-lane fields, lane 0 at LSBs.
interface oa_addr_gen_if #(
  parameter int LANES = 8,
  parameter int ROW_W = 10,
  parameter int COL_W = 11,
  parameter int CH_W  = 8
);
  logic                   ia_valid;
  logic                   ia_ready;
  logic [LANES*ROW_W-1:0] ia_row;
  logic [LANES*COL_W-1:0] ia_col;
  logic [LANES-1:0]       ia_mask;
  logic [CH_W-1:0]        concat_no;

  logic                   oa_valid;
  logic                   oa_ready;
  logic [LANES*ROW_W-1:0] oa_row;
  logic [LANES*COL_W-1:0] oa_col;
  logic [LANES*CH_W-1:0]  oa_ch;
  logic [LANES-1:0]       oa_mask;

  modport slave (
    input  ia_valid, ia_row, ia_col, ia_mask, concat_no, oa_ready,
    output ia_ready, oa_valid, oa_row, oa_col, oa_ch, oa_mask
  );

  modport master (
    output ia_valid, ia_row, ia_col, ia_mask, concat_no, oa_ready,
    input  ia_ready, oa_valid, oa_row, oa_col, oa_ch, oa_mask
  );
endinterface

// File: rtl/oa_addr_gen.sv
// OA address generator: 2-cycle pipeline (sums/range checks, output register), 1 beat/cycle.
// IA stalls when both stages are held by oa_ready=0; a weight switch blocks IA and drains first.
module oa_addr_gen #(
  parameter int LANES = 8,
  parameter int ROW_W = 10,
  parameter int COL_W = 11,
  parameter int CH_W  = 8,
  parameter int OFS_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cfg_load,
  input  logic                    i_cfg_stride2,
  input  logic [1:0]              i_cfg_dil,
  input  logic [ROW_W-1:0]        i_cfg_oa_rows,
  input  logic [COL_W-1:0]        i_cfg_oa_cols,
  input  logic                    i_wt_valid,
  output logic                    o_wt_ready,
  input  logic signed [OFS_W-1:0] i_wt_row_ofs,
  input  logic signed [OFS_W-1:0] i_wt_col_ofs,
  input  logic [CH_W-1:0]         i_wt_ker,
  output logic [CNT_W-1:0]        o_drop_cnt,
  output logic                    o_busy,
  oa_addr_gen_if.slave            io_bus
);

  localparam int RT = ROW_W + 3;
  localparam int CT = COL_W + 3;
  localparam int DW = $clog2(LANES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

  state_t                  r_state;
  logic                    r_stride2;
  logic [1:0]              r_dil;
  logic [ROW_W-1:0]        r_rows;
  logic [COL_W-1:0]        r_cols;
  logic signed [OFS_W-1:0] r_wt_row_ofs;
  logic signed [OFS_W-1:0] r_wt_col_ofs;
  logic [CH_W-1:0]         r_wt_ker;

  logic                    r_s1_vld;
  logic [LANES*ROW_W-1:0]  r_s1_row;
  logic [LANES*COL_W-1:0]  r_s1_col;
  logic [LANES-1:0]        r_s1_ok;
  logic [CH_W-1:0]         r_s1_ch;
  logic [DW-1:0]           r_s1_drop;

  logic                    r_s2_vld;
  logic [LANES*ROW_W-1:0]  r_s2_row;
  logic [LANES*COL_W-1:0]  r_s2_col;
  logic [LANES*CH_W-1:0]   r_s2_ch;
  logic [LANES-1:0]        r_s2_mask;
  logic [CNT_W-1:0]        r_drop_cnt;

  logic                    w_s2_free;
  logic                    w_s1_adv;
  logic                    w_s1_free;
  logic                    w_pipe_empty;
  logic                    w_ia_take;
  logic                    w_wt_take;
  logic                    w_cfg_take;
  logic [1:0]              w_dil;
  logic signed [RT-1:0]    w_row_ofs_x;
  logic signed [RT-1:0]    w_row_dil_x;
  logic signed [RT-1:0]    w_row_step;
  logic signed [CT-1:0]    w_col_ofs_x;
  logic signed [CT-1:0]    w_col_dil_x;
  logic signed [CT-1:0]    w_col_step;
  logic [LANES*ROW_W-1:0]  w_row_q;
  logic [LANES*COL_W-1:0]  w_col_q;
  logic [LANES-1:0]        w_ok;
  logic [DW-1:0]           w_drop;
  logic [CH_W-1:0]         w_ch;
  logic [CNT_W:0]          w_drop_sum;
  logic [CNT_W-1:0]        w_drop_sat;

  assign w_s2_free    = !r_s2_vld || io_bus.oa_ready;
  assign w_s1_adv     = r_s1_vld && w_s2_free;
  assign w_s1_free    = !r_s1_vld || w_s2_free;
  assign w_pipe_empty = !r_s1_vld && !r_s2_vld;

  // rst_n gating keeps wt_ready low while reset is held even though state decodes as IDLE.
  assign o_wt_ready = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_DRAIN) && w_pipe_empty));
  assign io_bus.ia_ready = (r_state == ST_ACTIVE) && !i_wt_valid && w_s1_free;

  assign w_ia_take  = io_bus.ia_valid && io_bus.ia_ready;
  assign w_wt_take  = i_wt_valid && o_wt_ready;
  assign w_cfg_take = i_cfg_load && (r_state == ST_IDLE);

  assign w_dil       = (r_dil == 2'd0) ? 2'd1 : r_dil;
  assign w_row_ofs_x = {{(RT-OFS_W){r_wt_row_ofs[OFS_W-1]}}, r_wt_row_ofs};
  assign w_col_ofs_x = {{(CT-OFS_W){r_wt_col_ofs[OFS_W-1]}}, r_wt_col_ofs};
  assign w_row_dil_x = {{(RT-2){1'b0}}, w_dil};
  assign w_col_dil_x = {{(CT-2){1'b0}}, w_dil};
  assign w_row_step  = w_row_ofs_x * w_row_dil_x;
  assign w_col_step  = w_col_ofs_x * w_col_dil_x;
  assign w_ch        = r_wt_ker + io_bus.concat_no;

  always_comb begin
    logic signed [RT-1:0] w_t_row;
    logic signed [RT-1:0] w_r_row;
    logic signed [CT-1:0] w_t_col;
    logic signed [CT-1:0] w_r_col;
    logic                 w_odd;
    logic                 w_row_in;
    logic                 w_col_in;
    w_row_q = '0;
    w_col_q = '0;
    w_ok    = '0;
    w_drop  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_t_row  = $signed({3'b000, io_bus.ia_row[i*ROW_W +: ROW_W]}) + w_row_step;
      w_t_col  = $signed({3'b000, io_bus.ia_col[i*COL_W +: COL_W]}) + w_col_step;
      w_r_row  = r_stride2 ? (w_t_row >>> 1) : w_t_row;
      w_r_col  = r_stride2 ? (w_t_col >>> 1) : w_t_col;
      // Stride 2 only lands on even sums; odd sums have no OA position.
      w_odd    = r_stride2 && (w_t_row[0] || w_t_col[0]);
      w_row_in = !w_r_row[RT-1] && (w_r_row < $signed({3'b000, r_rows}));
      w_col_in = !w_r_col[CT-1] && (w_r_col < $signed({3'b000, r_cols}));
      w_ok[i]  = io_bus.ia_mask[i] && !w_odd && w_row_in && w_col_in;
      if (w_ok[i]) begin
        w_row_q[i*ROW_W +: ROW_W] = w_r_row[ROW_W-1:0];
        w_col_q[i*COL_W +: COL_W] = w_r_col[COL_W-1:0];
      end
      if (io_bus.ia_mask[i] && !w_ok[i]) begin
        w_drop = w_drop + DW'(1);
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(r_s1_drop);
  assign w_drop_sat = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_stride2    <= 1'b0;
      r_dil        <= 2'd1;
      r_rows       <= '0;
      r_cols       <= '0;
      r_wt_row_ofs <= '0;
      r_wt_col_ofs <= '0;
      r_wt_ker     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_take) begin
            r_stride2 <= i_cfg_stride2;
            r_dil     <= i_cfg_dil;
            r_rows    <= i_cfg_oa_rows;
            r_cols    <= i_cfg_oa_cols;
          end
          if (w_wt_take) begin
            r_wt_row_ofs <= i_wt_row_ofs;
            r_wt_col_ofs <= i_wt_col_ofs;
            r_wt_ker     <= i_wt_ker;
            r_state      <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (i_wt_valid) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_wt_take) begin
            r_wt_row_ofs <= i_wt_row_ofs;
            r_wt_col_ofs <= i_wt_col_ofs;
            r_wt_ker     <= i_wt_ker;
            r_state      <= ST_ACTIVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: addresses already zeroed for invalid lanes; channel expanded per lane at stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_row  <= '0;
      r_s1_col  <= '0;
      r_s1_ok   <= '0;
      r_s1_ch   <= '0;
      r_s1_drop <= '0;
    end else if (w_ia_take) begin
      r_s1_vld  <= 1'b1;
      r_s1_row  <= w_row_q;
      r_s1_col  <= w_col_q;
      r_s1_ok   <= w_ok;
      r_s1_ch   <= w_ch;
      r_s1_drop <= w_drop;
    end else if (w_s1_adv) begin
      r_s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_row  <= '0;
      r_s2_col  <= '0;
      r_s2_ch   <= '0;
      r_s2_mask <= '0;
    end else if (w_s1_adv) begin
      r_s2_vld  <= 1'b1;
      r_s2_row  <= r_s1_row;
      r_s2_col  <= r_s1_col;
      r_s2_mask <= r_s1_ok;
      for (int i = 0; i < LANES; i++) begin
        r_s2_ch[i*CH_W +: CH_W] <= r_s1_ok[i] ? r_s1_ch : '0;
      end
    end else if (io_bus.oa_ready) begin
      r_s2_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_cfg_take) begin
      r_drop_cnt <= '0;
    end else if (w_s1_adv) begin
      r_drop_cnt <= w_drop_sat;
    end
  end

  assign io_bus.oa_valid = r_s2_vld;
  assign io_bus.oa_row   = r_s2_row;
  assign io_bus.oa_col   = r_s2_col;
  assign io_bus.oa_ch    = r_s2_ch;
  assign io_bus.oa_mask  = r_s2_mask;
  assign o_drop_cnt      = r_drop_cnt;
  assign o_busy          = (r_state != ST_IDLE) || r_s1_vld || r_s2_vld;

endmodule

// File: tb/tb_oa_addr_gen.sv
// Scoreboard bench for oa_addr_gen: directed beats push hand-computed expectations, a monitor pops on OA handshakes.
module tb_oa_addr_gen;
  localparam int LANES = 8;
  localparam int ROW_W = 10;
  localparam int COL_W = 11;
  localparam int CH_W  = 8;
  localparam int OFS_W = 4;
  localparam int CNT_W = 4;

  typedef int lane_t [LANES];
  typedef struct {
    logic [LANES*ROW_W-1:0] row;
    logic [LANES*COL_W-1:0] col;
    logic [LANES*CH_W-1:0]  ch;
    logic [LANES-1:0]       mask;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cfg_load;
  logic                    cfg_stride2;
  logic [1:0]              cfg_dil;
  logic [ROW_W-1:0]        cfg_rows;
  logic [COL_W-1:0]        cfg_cols;
  logic                    wt_valid;
  logic                    wt_ready;
  logic signed [OFS_W-1:0] wt_row_ofs;
  logic signed [OFS_W-1:0] wt_col_ofs;
  logic [CH_W-1:0]         wt_ker;
  logic [CNT_W-1:0]        drop_cnt;
  logic                    busy;

  oa_addr_gen_if #(.LANES(LANES), .ROW_W(ROW_W), .COL_W(COL_W), .CH_W(CH_W)) bus ();

  oa_addr_gen #(
    .LANES(LANES), .ROW_W(ROW_W), .COL_W(COL_W), .CH_W(CH_W), .OFS_W(OFS_W), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_load   (cfg_load),
    .i_cfg_stride2(cfg_stride2),
    .i_cfg_dil    (cfg_dil),
    .i_cfg_oa_rows(cfg_rows),
    .i_cfg_oa_cols(cfg_cols),
    .i_wt_valid   (wt_valid),
    .o_wt_ready   (wt_ready),
    .i_wt_row_ofs (wt_row_ofs),
    .i_wt_col_ofs (wt_col_ofs),
    .i_wt_ker     (wt_ker),
    .o_drop_cnt   (drop_cnt),
    .o_busy       (busy),
    .io_bus       (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rcv = 0;
  int   exp_drop = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LANES*ROW_W-1:0] pr(input lane_t v);
    logic [LANES*ROW_W-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i*ROW_W +: ROW_W] = ROW_W'(v[i]);
    return p;
  endfunction

  function automatic logic [LANES*COL_W-1:0] pc(input lane_t v);
    logic [LANES*COL_W-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i*COL_W +: COL_W] = COL_W'(v[i]);
    return p;
  endfunction

  function automatic logic [LANES*CH_W-1:0] pch(input int ch, input logic [LANES-1:0] m);
    logic [LANES*CH_W-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) if (m[i]) p[i*CH_W +: CH_W] = CH_W'(ch);
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.oa_valid && bus.oa_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got row %0h required no beat", bus.oa_row);
      end else begin
        mon_e = sb.pop_front();
        chk("oa_row",  128'(bus.oa_row),  128'(mon_e.row));
        chk("oa_col",  128'(bus.oa_col),  128'(mon_e.col));
        chk("oa_ch",   128'(bus.oa_ch),   128'(mon_e.ch));
        chk("oa_mask", 128'(bus.oa_mask), 128'(mon_e.mask));
        n_rcv++;
      end
    end
  end

  task automatic send(input lane_t rows, input lane_t cols, input logic [LANES-1:0] mask,
                      input int cnc, input lane_t erow, input lane_t ecol, input int ech,
                      input logic [LANES-1:0] emask);
    int   n;
    exp_t e;
    bus.ia_row    = pr(rows);
    bus.ia_col    = pc(cols);
    bus.ia_mask   = mask;
    bus.concat_no = CH_W'(cnc);
    bus.ia_valid  = 1'b1;
    e.row  = pr(erow);
    e.col  = pc(ecol);
    e.ch   = pch(ech, emask);
    e.mask = emask;
    n = 0;
    @(negedge clk);
    while (!bus.ia_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ia_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ia_accept_timeout: ia_ready %0b required 1", bus.ia_ready);
    end else begin
      @(posedge clk);
      sb.push_back(e);
      exp_drop = exp_drop + $countones(mask & ~emask);
      if (exp_drop > 15) exp_drop = 15;
    end
    #1 bus.ia_valid = 1'b0;
  endtask

  task automatic do_weight(input int ro, input int co, input int ker);
    int n;
    wt_row_ofs = OFS_W'(ro);
    wt_col_ofs = OFS_W'(co);
    wt_ker     = CH_W'(ker);
    wt_valid   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wt_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!wt_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL wt_accept_timeout: wt_ready %0b required 1", wt_ready);
    end
    @(posedge clk);
    #1 wt_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic s2, input int dil, input int rows, input int cols);
    cfg_stride2 = s2;
    cfg_dil     = 2'(dil);
    cfg_rows    = ROW_W'(rows);
    cfg_cols    = COL_W'(cols);
    cfg_load    = 1'b1;
    @(posedge clk);
    #1 cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wt_ready", 128'(wt_ready),      128'd0);
    chk("rst_ia_ready", 128'(bus.ia_ready),  128'd0);
    chk("rst_oa_valid", 128'(bus.oa_valid),  128'd0);
    chk("rst_oa_mask",  128'(bus.oa_mask),   128'd0);
    chk("rst_oa_row",   128'(bus.oa_row),    128'd0);
    chk("rst_drop_cnt", 128'(drop_cnt),      128'd0);
    chk("rst_busy",     128'(busy),          128'd0);
    #1 rst_n = 1'b1;
    exp_drop = 0;
    @(negedge clk);
    chk("post_rst_wt_ready", 128'(wt_ready), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    cfg_load = 1'b0; cfg_stride2 = 1'b0; cfg_dil = 2'd0; cfg_rows = '0; cfg_cols = '0;
    wt_valid = 1'b0; wt_row_ofs = '0; wt_col_ofs = '0; wt_ker = '0;
    bus.ia_valid = 1'b0; bus.ia_row = '0; bus.ia_col = '0; bus.ia_mask = '0; bus.concat_no = '0;
    bus.oa_ready = 1'b1;
    do_reset();

    // Basic offset and channel sum, with latency check.
    do_cfg(1'b0, 1, 16, 16);
    do_weight(-1, 1, 3);
    send('{5,0,0,0,0,0,0,0}, '{5,0,0,0,0,0,0,0}, 8'h01, 4,
         '{4,0,0,0,0,0,0,0}, '{6,0,0,0,0,0,0,0}, 7, 8'h01);
    @(negedge clk);
    chk("lat_cycle1_oa_valid", 128'(bus.oa_valid), 128'd0);
    @(negedge clk);
    chk("lat_cycle2_oa_valid", 128'(bus.oa_valid), 128'd1);
    settle();
    chk("t1_drop_cnt", 128'(drop_cnt), 128'(exp_drop));

    // Bounds: negative rows and row == extent are dropped.
    do_weight(-2, 0, 3);
    send('{0,1,2,18,0,0,0,0}, '{3,3,3,3,0,0,0,0}, 8'h0F, 0,
         '{0,0,0,0,0,0,0,0}, '{0,0,3,0,0,0,0,0}, 3, 8'h04);
    settle();
    chk("bounds_drop_cnt", 128'(drop_cnt), 128'd3);

    // Stride 2, dilation 2.
    do_reset();
    do_cfg(1'b1, 2, 16, 16);
    do_weight(1, 1, 5);
    send('{4,5,4,0,0,0,0,0}, '{4,5,5,4,0,0,0,0}, 8'h0F, 1,
         '{3,0,0,1,0,0,0,0}, '{3,0,0,3,0,0,0,0}, 6, 8'h09);
    settle();
    chk("stride_drop_cnt", 128'(drop_cnt), 128'd2);

    // Backpressure, dilation 0 behaves as 1.
    do_reset();
    do_cfg(1'b0, 0, 8, 20);
    do_weight(2, -3, 10);
    bus.oa_ready = 1'b0;
    for (int k = 0; k < 2; k++)
      send('{k,6,0,0,0,0,0,0}, '{3+k,0,0,0,0,0,0,0}, 8'h03, k,
           '{k+2,0,0,0,0,0,0,0}, '{k,0,0,0,0,0,0,0}, 10+k, 8'h01);
    @(negedge clk);
    chk("bp_ia_ready_full", 128'(bus.ia_ready), 128'd0);
    chk("bp_oa_valid",      128'(bus.oa_valid), 128'd1);
    chk("bp_oa_ch_head",    128'(bus.oa_ch),    128'd10);
    repeat (2) begin
      @(negedge clk);
      chk("bp_oa_row_hold",  128'(bus.oa_row),   128'd2);
      chk("bp_ia_ready_low", 128'(bus.ia_ready), 128'd0);
    end
    @(posedge clk);
    #1 bus.oa_ready = 1'b1;
    for (int k = 2; k < 5; k++)
      send('{k,6,0,0,0,0,0,0}, '{3+k,0,0,0,0,0,0,0}, 8'h03, k,
           '{k+2,0,0,0,0,0,0,0}, '{k,0,0,0,0,0,0,0}, 10+k, 8'h01);
    settle();
    chk("bp_drop_cnt", 128'(drop_cnt), 128'd5);

    // Weight switch with two beats in flight.
    send('{1,0,0,0,0,0,0,0}, '{4,0,0,0,0,0,0,0}, 8'h01, 0,
         '{3,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0}, 10, 8'h01);
    send('{2,0,0,0,0,0,0,0}, '{5,0,0,0,0,0,0,0}, 8'h01, 0,
         '{4,0,0,0,0,0,0,0}, '{2,0,0,0,0,0,0,0}, 10, 8'h01);
    bus.oa_ready = 1'b0;
    wt_row_ofs = '0;
    wt_col_ofs = '0;
    wt_ker = CH_W'(20);
    wt_valid = 1'b1;
    @(negedge clk);
    chk("ws_ia_ready_now", 128'(bus.ia_ready), 128'd0);
    @(negedge clk);
    chk("ws_wt_ready_full", 128'(wt_ready),     128'd0);
    chk("ws_ia_ready_drain", 128'(bus.ia_ready), 128'd0);
    @(posedge clk);
    #1 bus.oa_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wt_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!wt_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ws_wt_ready_timeout: wt_ready %0b required 1", wt_ready);
    end else begin
      chk("ws_drained_before_ready", 128'(sb.size()), 128'd0);
    end
    @(posedge clk);
    #1 wt_valid = 1'b0;
    send('{3,7,8,0,0,0,0,0}, '{3,19,0,0,0,0,0,0}, 8'h07, 2,
         '{3,7,0,0,0,0,0,0}, '{3,19,0,0,0,0,0,0}, 22, 8'h03);
    settle();
    chk("ws_drop_cnt", 128'(drop_cnt), 128'd6);

    // Saturating drop counter (4 bits).
    send('{100,100,100,100,100,100,100,100}, '{0,0,0,0,0,0,0,0}, 8'hFF, 0,
         '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, 0, 8'h00);
    settle();
    chk("sat_drop_cnt_14", 128'(drop_cnt), 128'd14);
    for (int k = 0; k < 2; k++)
      send('{100,100,100,100,100,100,100,100}, '{0,0,0,0,0,0,0,0}, 8'hFF, 0,
           '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, 0, 8'h00);
    settle();
    chk("sat_drop_cnt_15", 128'(drop_cnt), 128'd15);
    chk("beats_received", 128'(n_rcv), 128'd14);

    // Asynchronous reset with a beat held in the output register.
    bus.oa_ready = 1'b0;
    send('{1,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0}, 8'h01, 0,
         '{1,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0}, 20, 8'h01);
    @(posedge clk);
    #2;
    chk("pre_arst_oa_valid", 128'(bus.oa_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_oa_valid", 128'(bus.oa_valid), 128'd0);
    chk("arst_oa_mask",  128'(bus.oa_mask),  128'd0);
    chk("arst_oa_row",   128'(bus.oa_row),   128'd0);
    chk("arst_oa_ch",    128'(bus.oa_ch),    128'd0);
    chk("arst_drop_cnt", 128'(drop_cnt),     128'd0);
    chk("arst_busy",     128'(busy),         128'd0);
    chk("arst_wt_ready", 128'(wt_ready),     128'd0);
    sb.delete();
    exp_drop = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.oa_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_arst_no_beat", 128'(bus.oa_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
